// File: rtl/riscv_pkg.sv
// Shared types and helpers for the RISC-V data-memory controller.
//   mem_size_e   : access size encoding of req_size (BYTE, HALF, WORD)
//   dmem_state_e : controller FSM states
//   merge_store  : inserts store data into a read word at the addressed lane
package riscv_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } dmem_state_e;

  // Read-modify-write merge: low byte/half of store data replaces the lane at lane[1:0]
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] merged;
    merged = word;
    if (size == BYTE) begin
      merged[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (size == HALF) begin
      merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    end else begin
      merged = wdata;
    end
    return merged;
  endfunction

endpackage

// File: rtl/riscv_load_ext.sv
// Load lane extraction and sign/zero extension (combinational).
// Ports:
//   rdata  in  raw RAM word
//   addr   in  byte offset within the word
//   size   in  access size (mem_size_e encoding)
//   uns    in  1 = zero-extend, 0 = sign-extend
//   data_c out extended load data
module riscv_load_ext
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            addr,
  input  logic [1:0]            size,
  input  logic                  uns,
  output logic [DATA_WIDTH-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata[{addr, 3'b000} +: 8];
    half_c = rdata[{addr[1], 4'b0000} +: 16];
    data_c = rdata;
    case (size)
      BYTE: data_c = uns ? {{(DATA_WIDTH-8){1'b0}}, byte_c}
                         : {{(DATA_WIDTH-8){byte_c[7]}}, byte_c};
      HALF: data_c = uns ? {{(DATA_WIDTH-16){1'b0}}, half_c}
                         : {{(DATA_WIDTH-16){half_c[15]}}, half_c};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// RISC-V data-memory controller: byte/half/word loads and stores onto a
// single-port word RAM with one-cycle read latency. Sub-word stores use a
// read-modify-write sequence when RISCV_DMEM_RMW_EN is defined; otherwise
// they are rejected with rsp_err.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_we, req_addr, req_size,
//   req_unsigned, req_wdata            request payload (byte address)
//   rsp_valid, rsp_err, rsp_rdata      one-cycle response pulse, error, load data
//   ram_cs, ram_we, ram_addr,
//   ram_wr_data, ram_rd_data           RAM port (word address)
// Configuration macro: RISCV_DMEM_RMW_EN
module riscv_dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned BADDR_W = ADDR_WIDTH + 2;

  dmem_state_e           state_q, state_d;
  logic                  we_q;
  logic                  uns_q;
  logic [BADDR_W-1:0]    addr_q;
  logic [1:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept_c;
  logic                  req_err_c;
  logic [DATA_WIDTH-1:0] load_data_c;

  assign accept_c = req_valid & req_ready;

  // Request legality: alignment, reserved size, and sub-word stores without RMW
  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      BYTE:    req_err_c = 1'b0;
      HALF:    req_err_c = req_addr[0];
      WORD:    req_err_c = |req_addr[1:0];
      default: req_err_c = 1'b1;
    endcase
`ifndef RISCV_DMEM_RMW_EN
    if (req_we && (req_size != WORD)) req_err_c = 1'b1;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err_c)                       state_d = RESP;
          else if (req_we && req_size == WORD) state_d = WR;
          else                                 state_d = RD;
        end
      end
      RD:      state_d = RDW;
      RDW:     state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture; RDW either merges the store or registers the load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
    end else if (accept_c) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
    end else if (state_q == RDW) begin
      if (we_q) wdata_q   <= DATA_WIDTH'(merge_store(32'(ram_rd_data), 32'(wdata_q),
                                                     addr_q[1:0], size_q));
      else      rsp_rdata <= load_data_c;
    end
  end

  // Registered handshake/RAM strobes decoded from the upcoming state.
  // Errors are the only path that reaches RESP straight from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
    end else begin
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      rsp_err   <= (state_q == IDLE) && (state_d == RESP);
      ram_cs    <= (state_d == RD) || (state_d == WR);
      ram_we    <= (state_d == WR);
    end
  end

  assign ram_addr    = addr_q[BADDR_W-1:2];
  assign ram_wr_data = wdata_q;

  riscv_load_ext #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_ext (
    .rdata  (ram_rd_data),
    .addr   (addr_q[1:0]),
    .size   (size_q),
    .uns    (uns_q),
    .data_c (load_data_c)
  );

endmodule
